// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// comm_pkg
// Shared definitions for the host command link: frame-state encoding,
// command byte values, the acknowledge byte and a counter-width helper.
// Revision: 1.0
// ============================================================================
package comm_pkg;

  // Frame assembly states: waiting for cmd, data[15:8], data[7:0]
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } frame_state_e;

  // Command byte encodings understood by the command processor
  localparam logic [7:0] CMD_PTCH  = 8'h02;
  localparam logic [7:0] CMD_ROLL  = 8'h03;
  localparam logic [7:0] CMD_YAW   = 8'h04;
  localparam logic [7:0] CMD_THRST = 8'h05;
  localparam logic [7:0] CMD_CAL   = 8'h06;
  localparam logic [7:0] CMD_EMER  = 8'h07;
  localparam logic [7:0] CMD_MOFF  = 8'h08;

  // Positive acknowledge returned to the host
  localparam logic [7:0] ACK = 8'hA5;

  // Width of a counter that must hold values 0..n-1 (never less than 1 bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_wrapper_if.sv
`default_nettype none
// ============================================================================
// uart_cmd_wrapper_if
// Command/response handshake between the UART command wrapper (master) and
// the command processor (slave).
// Revision: 1.0
// ============================================================================
interface uart_cmd_wrapper_if;

  logic [7:0]  cmd;          // command byte of last complete frame
  logic [15:0] data;         // data word of last complete frame
  logic        cmd_rdy;      // level: a complete frame is held
  logic        clr_cmd_rdy;  // pulse: consumer knocks down cmd_rdy
  logic [7:0]  resp;         // response byte to transmit
  logic        send_resp;    // pulse: start transmitting resp
  logic        resp_sent;    // pulse: response stop bit completed

  modport master (
    output cmd, data, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd, data, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

endinterface
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// uart_xcvr
// Bit-level 8N1 UART: RX synchroniser, mid-bit sampler and framing check,
// plus an independent TX shifter. Byte handshake on rx_byte/rx_rdy and
// tx_byte/trmt/tx_done.
// Revision: 1.0
// ============================================================================
module uart_xcvr
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  wire        clk,
  input  wire        rst,
  input  wire        rx_i,
  output logic       tx_o,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       frm_err_o,
  input  wire  [7:0] tx_byte,
  input  wire        trmt,
  output logic       tx_done
);

  localparam int            CW      = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // ---------------------------------------------------------------- RX ----
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          w_fall, w_tick;

  assign w_fall = rx_prev_q & ~rx_sync_q;
  // The start bit is checked half a bit in; all later bits a full bit apart
  assign w_tick = (rx_st_q == RX_START) ? (rx_cnt_q == HALF_M1)
                                        : (rx_cnt_q == FULL_M1);

  // Two-flop synchroniser plus edge-detect history; idle level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) rx_st_q <= RX_IDLE;
    else     rx_st_q <= rx_st_d;
  end

  // Receiver next state: glitch rejection at start mid-bit, 8 data, stop
  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      RX_IDLE:  if (w_fall) rx_st_d = RX_START;
      RX_START: if (w_tick) rx_st_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      RX_STOP:  if (w_tick) rx_st_d = RX_IDLE;
      default:  rx_st_d = RX_IDLE;
    endcase
  end

  // Receiver outputs: good byte or framing error, both at the stop mid-bit
  always_comb begin
    rx_rdy    = (rx_st_q == RX_STOP) && w_tick &&  rx_sync_q;
    frm_err_o = (rx_st_q == RX_STOP) && w_tick && !rx_sync_q;
    rx_byte   = rx_shift_q;
  end

  // Receiver datapath: baud counter, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      if (rx_st_q == RX_IDLE || w_tick) rx_cnt_q <= '0;
      else                              rx_cnt_q <= rx_cnt_q + CW'(1);

      if (rx_st_q != RX_DATA)                   rx_bit_q <= 3'd0;
      else if (w_tick && rx_bit_q != 3'd7)      rx_bit_q <= rx_bit_q + 3'd1;

      if (rx_st_q == RX_DATA && w_tick) rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
    end
  end

  // ---------------------------------------------------------------- TX ----
  logic          tx_busy_q;
  logic          tx_q;
  logic [7:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;   // 0 = start, 1..8 = data, 9 = stop
  logic          tx_done_q;

  assign tx_o    = tx_q;
  assign tx_done = tx_done_q;

  // Transmit shifter; requests while busy are dropped, line is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_shift_q <= 8'h00;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        tx_q     <= 1'b1;
        tx_cnt_q <= '0;
        tx_bit_q <= 4'd0;
        if (trmt) begin
          tx_busy_q  <= 1'b1;
          tx_q       <= 1'b0;
          tx_shift_q <= tx_byte;
        end
      end else if (tx_cnt_q == FULL_M1) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_q      <= 1'b1;
          tx_done_q <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_q       <= (tx_bit_q == 4'd8) ? 1'b1 : tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// uart_cmd_wrapper
// Copter-side host command link: assembles 3-byte frames (cmd, data hi,
// data lo) from the UART, presents them with cmd_rdy, and returns a single
// response byte. Optional inter-byte timeout: FRAME_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module uart_cmd_wrapper
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_BITS = 20
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              RX,
  output logic             TX,
  uart_cmd_wrapper_if.master bus
);

  logic [7:0]   w_rx_byte;
  logic         w_rx_rdy, w_frm_err, w_tmo;
  logic         w_ld_cmd, w_ld_hi, w_done;
  frame_state_e state_q, state_d;
  logic [7:0]   sh_cmd_q, sh_hi_q, cmd_q;
  logic [15:0]  data_q;
  logic         set_pend_q, cmd_rdy_q;

  uart_xcvr #(
    .BAUD_DIV (BAUD_DIV)
  ) u_xcvr (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .tx_o      (TX),
    .rx_byte   (w_rx_byte),
    .rx_rdy    (w_rx_rdy),
    .frm_err_o (w_frm_err),
    .tx_byte   (bus.resp),
    .trmt      (bus.send_resp),
    .tx_done   (bus.resp_sent)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_CYC = TMO_BITS * BAUD_DIV;
  localparam int GW      = cnt_width(TMO_CYC + 1);
  logic [GW-1:0] gap_q;

  // Inter-byte gap timer: only runs while a frame is partially assembled
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE || w_rx_rdy) gap_q <= '0;
    else                                    gap_q <= gap_q + GW'(1);
  end

  assign w_tmo = (gap_q == GW'(TMO_CYC - 1));
`else
  // No timeout: a partial frame waits for its remaining bytes indefinitely;
  // the term keeps TMO_BITS referenced in this build
  assign w_tmo = 1'b0 & (TMO_BITS > 0);
`endif

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame next state; a received byte takes priority over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    if (w_frm_err) begin
      state_d = IDLE;
    end else if (w_rx_rdy) begin
      case (state_q)
        IDLE:    state_d = WAIT_HI;
        WAIT_HI: state_d = WAIT_LO;
        WAIT_LO: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (w_tmo) begin
      state_d = IDLE;
    end
  end

  // Frame outputs: which register each incoming byte is steered into
  always_comb begin
    w_ld_cmd = (state_q == IDLE)    && w_rx_rdy;
    w_ld_hi  = (state_q == WAIT_HI) && w_rx_rdy;
    w_done   = (state_q == WAIT_LO) && w_rx_rdy;
  end

  // Shadow and visible registers; cmd/data only move on frame completion
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_cmd_q   <= 8'h00;
      sh_hi_q    <= 8'h00;
      cmd_q      <= 8'h00;
      data_q     <= 16'h0000;
      set_pend_q <= 1'b0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      if (w_ld_cmd) sh_cmd_q <= w_rx_byte;
      if (w_ld_hi)  sh_hi_q  <= w_rx_byte;
      if (w_done) begin
        cmd_q  <= sh_cmd_q;
        data_q <= {sh_hi_q, w_rx_byte};
      end
      set_pend_q <= w_done;
      // Setting beats a coincident clear
      if (set_pend_q)                        cmd_rdy_q <= 1'b1;
      else if (bus.clr_cmd_rdy || w_ld_cmd)  cmd_rdy_q <= 1'b0;
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.data    = data_q;
  assign bus.cmd_rdy = cmd_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_wrapper
// Self-checking bench for uart_cmd_wrapper at 16 clocks per bit. A bench
// UART drives RX; frames and expected cmd/data come from a vector table,
// followed by hand-written corner-case sequences.
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_wrapper;
  import comm_pkg::*;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RX  = 1'b1;
  logic TX;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_wrapper_if bus ();

  uart_cmd_wrapper #(
    .BAUD_DIV (BAUD),
    .TMO_BITS (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .RX  (RX),
    .TX  (TX),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  h;
    logic [7:0]  l;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. The stop-bit mid sample inside the DUT lands on
  // posedge 155 counted from the start-bit drive (2 sync + 1 edge detect +
  // 8 half-bit + 9*16), so cmd_rdy must first read 1 after posedge 156.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit last, input bit clr_done);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      RX = fr[j];
      for (int i = 1; i <= BAUD; i++) begin
        @(negedge clk);
        if (j == 9 && last) begin
          if (clr_done && i == 10) bus.clr_cmd_rdy = 1'b1;
          if (i == 11) check("lat_pre", 32'(bus.cmd_rdy), 32'd0);
          if (i == 12) begin
            check("lat_rise", 32'(bus.cmd_rdy), 32'd1);
            bus.clr_cmd_rdy = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input bit clr_done);
    send_byte(c, 1'b1, 1'b0, 1'b0);
    send_byte(h, 1'b1, 1'b0, 1'b0);
    send_byte(l, 1'b1, 1'b1, clr_done);
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] c, input logic [15:0] d);
    check({tag, "_cmd"},  32'(bus.cmd),     32'(c));
    check({tag, "_data"}, 32'(bus.data),    32'(d));
    check({tag, "_rdy"},  32'(bus.cmd_rdy), 32'd1);
  endtask

  // Response transmitter: waveform, single resp_sent at clk 160, no requeue
  task automatic tx_test();
    logic [9:0] w;
    int pulses;
    int first;
    w      = 10'b1101001010;   // start, A5 LSB first, stop
    pulses = 0;
    first  = -1;
    bus.resp      = ACK;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k == 50) bus.send_resp = 1'b1;
      if (k == 51) bus.send_resp = 1'b0;
      if (bus.resp_sent) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k % 16 == 8 && k < 160)
        check($sformatf("tx_bit%0d", k / 16), 32'(TX), 32'(w[k / 16]));
      if (k == 170) check("tx_no_requeue", 32'(TX), 32'd1);
      @(negedge clk);
    end
    check("resp_sent_count", 32'(pulses), 32'd1);
    check("resp_sent_clk",   32'(first),  32'd160);
  endtask

  initial begin
    logic [9:0] fr;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp        = 8'h00;

    vecs[0] = '{c: CMD_THRST, h: 8'h00, l: 8'hFF, exp_cmd: 8'h05, exp_data: 16'h00FF};
    vecs[1] = '{c: CMD_EMER,  h: 8'hA5, l: 8'h5A, exp_cmd: 8'h07, exp_data: 16'hA55A};
    vecs[2] = '{c: CMD_MOFF,  h: 8'h12, l: 8'h34, exp_cmd: 8'h08, exp_data: 16'h1234};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx",        32'(TX),            32'd1);
    check("rst_cmd",       32'(bus.cmd),       32'd0);
    check("rst_data",      32'(bus.data),      32'd0);
    check("rst_cmd_rdy",   32'(bus.cmd_rdy),   32'd0);
    check("rst_resp_sent", 32'(bus.resp_sent), 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Table-driven frames: decode, then consumer clear
    for (int v = 0; v < 3; v++) begin
      send_frame(vecs[v].c, vecs[v].h, vecs[v].l, 1'b0);
      repeat (2) @(negedge clk);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_cmd, vecs[v].exp_data);
      pulse_clr();
      check($sformatf("vec%0d_clr", v), 32'(bus.cmd_rdy), 32'd0);
      check($sformatf("vec%0d_hold", v), 32'(bus.data), 32'(vecs[v].exp_data));
      idle_bits(1);
    end

    // Clear coinciding with completion: set wins
    send_frame(8'h03, 8'hFF, 8'h80, 1'b1);
    repeat (3) @(negedge clk);
    check_frame("setwins", 8'h03, 16'hFF80);

    // New frame while cmd_rdy held: drops on first byte, outputs stay put
    idle_bits(1);
    send_byte(8'h02, 1'b1, 1'b0, 1'b0);
    check("nf_b1_rdy",  32'(bus.cmd_rdy), 32'd0);
    check("nf_b1_cmd",  32'(bus.cmd),     32'h03);
    check("nf_b1_data", 32'(bus.data),    32'hFF80);
    send_byte(8'h01, 1'b1, 1'b0, 1'b0);
    check("nf_b2_cmd",  32'(bus.cmd),     32'h03);
    check("nf_b2_data", 32'(bus.data),    32'hFF80);
    send_byte(8'h00, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("nf", 8'h02, 16'h0100);

    // Framing errors: byte dropped, partial frame abandoned
    idle_bits(1);
    send_byte(8'h04, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    check("fe_rdy_kept", 32'(bus.cmd_rdy), 32'd1);
    send_byte(8'h07, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    send_byte(8'h04, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    send_frame(8'h06, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("fe", 8'h06, 16'h0000);
    pulse_clr();

    // Response transmitter
    idle_bits(1);
    tx_test();

    // Reset in the middle of the WAIT_LO byte, with TX also mid-frame
    idle_bits(1);
    send_byte(8'h02, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    bus.resp      = 8'h00;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    fr = {1'b1, 8'h22, 1'b0};
    for (int j = 0; j < 5; j++) begin
      RX = fr[j];
      repeat (BAUD) @(negedge clk);
    end
    check("rstmid_tx_busy", 32'(TX), 32'd0);
    rst = 1'b1;
    RX  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_tx",   32'(TX),          32'd1);
    check("rstmid_cmd",  32'(bus.cmd),     32'd0);
    check("rstmid_data", 32'(bus.data),    32'd0);
    check("rstmid_rdy",  32'(bus.cmd_rdy), 32'd0);
    idle_bits(12);
    check("rstmid_rdy_late", 32'(bus.cmd_rdy), 32'd0);
    check("rstmid_tx_late",  32'(TX),          32'd1);
    send_frame(8'h08, 8'hAB, 8'hCD, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("rstmid", 8'h08, 16'hABCD);
    pulse_clr();

    // Long gap after one byte
    idle_bits(1);
    send_byte(8'h07, 1'b1, 1'b0, 1'b0);
    idle_bits(21);
`ifdef FRAME_TIMEOUT_EN
    send_frame(8'h08, 8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("gap", 8'h08, 16'h1234);
`else
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(8'h34, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("gap", 8'h07, 16'h1234);
`endif

    idle_bits(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d, failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
